// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter sharing one LCD controller byte port between NREQ requesters,
// with per-transaction port lock and post-done settle delay. Optional macro: LCD_ARB_TIMEOUT_EN.

module lcd_write_arbiter #(
    parameter int NREQ           = 2,
    parameter int DLY_CYCLES     = 262142,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_rs,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        lcd_data,
    output logic              lcd_rs,
    output logic              lcd_start,
    input  logic              lcd_done,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (DLY_CYCLES > 0) ? $clog2(DLY_CYCLES + 1) : 1;
    localparam logic [PW-1:0] LAST_IDX   = PW'(NREQ - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'((DLY_CYCLES > 0) ? DLY_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        SETTLE    = 2'd3
    } state_t;

    state_t          stateR;
    state_t          nextStateS;
    logic [PW-1:0]   rrPtrR;
    logic [PW-1:0]   ownerR;
    logic [PW-1:0]   winnerS;
    logic [PW-1:0]   nextPtrS;
    logic [NREQ-1:0] oneHotS;
    logic [CW-1:0]   settleCntR;
    logic            lockR;
    logic            winValidS;
    logic            acceptS;
    logic            doneS;
    logic            timeoutS;
    logic            settleDoneS;
    logic            enterIdleS;

    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            return PW'(s - NREQ);
        end else begin
            return PW'(s);
        end
    endfunction

    // Winner select: lock owner only, else first valid at or above rrPtr with wrap.
    // Scanning from the far end lets the nearest requester overwrite the others.
    always_comb begin
        winnerS   = ownerR;
        winValidS = 1'b0;
        if (lockR) begin
            winnerS   = ownerR;
            winValidS = req_valid[ownerR];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                winnerS   = req_valid[wrapIdx(rrPtrR, k)] ? wrapIdx(rrPtrR, k) : winnerS;
                winValidS = winValidS | req_valid[wrapIdx(rrPtrR, k)];
            end
        end
    end

    // One-hot decode of the winner for the accept strobe and grant.
    always_comb begin
        oneHotS          = '0;
        oneHotS[winnerS] = 1'b1;
    end

    assign acceptS     = !rst && (stateR == IDLE) && winValidS;
    assign req_ready   = acceptS ? oneHotS : '0;
    assign doneS       = (stateR == WAIT_DONE) && lcd_done;
    assign settleDoneS = (stateR == SETTLE) && (settleCntR == SETTLE_END);
    assign nextPtrS    = (ownerR == LAST_IDX) ? '0 : ownerR + PW'(1);
    assign enterIdleS  = (stateR != IDLE) && (nextStateS == IDLE);

    // Next-state logic.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            IDLE: begin
                if (acceptS) nextStateS = ISSUE;
                else         nextStateS = IDLE;
            end
            ISSUE: nextStateS = WAIT_DONE;
            WAIT_DONE: begin
                if (doneS || timeoutS) nextStateS = (DLY_CYCLES == 0) ? IDLE : SETTLE;
                else                   nextStateS = WAIT_DONE;
            end
            SETTLE: begin
                if (settleDoneS) nextStateS = IDLE;
                else             nextStateS = SETTLE;
            end
            default: nextStateS = IDLE;
        endcase
    end

    // State, ownership, output byte and settle counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateR     <= IDLE;
            rrPtrR     <= '0;
            ownerR     <= '0;
            lockR      <= 1'b0;
            grant      <= '0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_start  <= 1'b0;
            busy       <= 1'b0;
            settleCntR <= '0;
        end else begin
            stateR    <= nextStateS;
            lcd_start <= acceptS;
            busy      <= (nextStateS != IDLE);
            if (acceptS) begin
                lcd_data <= req_data[{winnerS, 3'b000} +: 8];
                lcd_rs   <= req_rs[winnerS];
                grant    <= oneHotS;
                ownerR   <= winnerS;
                lockR    <= ~req_last[winnerS];
            end else if (timeoutS) begin
                lockR  <= 1'b0;
                rrPtrR <= nextPtrS;
                grant  <= '0;
            end else if (enterIdleS && !lockR) begin
                rrPtrR <= nextPtrS;
                grant  <= '0;
            end
            if ((stateR == SETTLE) && !settleDoneS) settleCntR <= settleCntR + CW'(1);
            else                                    settleCntR <= '0;
        end
    end

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_END = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] toCntR;

    assign timeoutS = (stateR == WAIT_DONE) && !lcd_done && (toCntR == TO_END);

    // WAIT_DONE watchdog; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            toCntR      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if ((stateR == WAIT_DONE) && !lcd_done && !timeoutS) toCntR <= toCntR + TW'(1);
            else                                                 toCntR <= '0;
            if (timeoutS) timeout_err <= 1'b1;
        end
    end
`else
    assign timeoutS    = 1'b0;
    assign timeout_err = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed self-checking bench for lcd_write_arbiter (NREQ=2, DLY_CYCLES=4), with a
// controller model answering lcd_done three cycles after each lcd_start.

module tb_lcd_write_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_rs;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_start;
    logic        lcd_done;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    logic [2:0]  doneSh;
    logic        doneEn;
    logic        manualDone;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    lcd_write_arbiter #(.NREQ(2), .DLY_CYCLES(4), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_rs(req_rs), .req_last(req_last), .req_ready(req_ready),
        .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_start(lcd_start),
        .lcd_done(lcd_done), .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) doneSh <= 3'b000;
        else     doneSh <= {doneSh[1:0], lcd_start};
    end
    assign lcd_done = (doneSh[2] & doneEn) | manualDone;

    always @(negedge clk) begin
        if (req_ready !== 2'b00) begin
            checks++;
            if ($countones(req_ready) != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ready_onehot ready=%b busy=%b expected one-hot while idle", req_ready, busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic doReset;
        rst = 1'b1; req_valid = 2'b00; doneEn = 1'b1; manualDone = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic waitAcc(output int idx, output int c);
        idx = -1; c = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) begin
                idx = (req_ready == 2'b10) ? 1 : 0;
                c   = cyc;
                break;
            end
        end
        if (idx < 0) begin
            checks++; errors++;
            $display("FAIL wait_accept no req_ready within 60 cycles");
        end
    endtask

    task automatic test_reset;
        int idx, c;
        rst = 1'b1; req_valid = 2'b11; req_last = 2'b11; req_rs = 2'b00;
        req_data = 16'h2211; doneEn = 1'b1; manualDone = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) @(negedge clk);
            else begin @(posedge clk); #1; end
            checks++;
            if (req_ready !== 2'b00 || lcd_start !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 ||
                lcd_data !== 8'h00 || lcd_rs !== 1'b0 || timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs ready=%b start=%b grant=%b busy=%b data=%h rs=%b terr=%b expected all 0",
                         req_ready, lcd_start, grant, busy, lcd_data, lcd_rs, timeout_err);
            end
        end
        #1 rst = 1'b0;
        waitAcc(idx, c);
        checks++;
        if (idx !== 0) begin errors++; $display("FAIL reset_first_winner got %0d expected 0", idx); end
        @(posedge clk); #2 req_valid = 2'b00;
    endtask

    task automatic test_single_byte;
        int idx, n, f;
        doReset();
        req_data[7:0] = 8'h38; req_rs[0] = 1'b0; req_last[0] = 1'b1; req_valid = 2'b01;
        waitAcc(idx, n);
        checks++;
        if (idx !== 0) begin errors++; $display("FAIL single_winner got %0d expected 0", idx); end
        @(posedge clk); #2 req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (lcd_start !== 1'b1) begin errors++; $display("FAIL single_start got %b expected 1", lcd_start); end
        checks++;
        if (lcd_data !== 8'h38 || lcd_rs !== 1'b0) begin
            errors++; $display("FAIL single_data got %h rs %b expected 38 rs 0", lcd_data, lcd_rs);
        end
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL single_grant got grant %b busy %b expected 01 1", grant, busy);
        end
        @(negedge clk);
        checks++;
        if (lcd_start !== 1'b0) begin errors++; $display("FAIL single_start_width got %b expected 0", lcd_start); end
        f = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin f = cyc; break; end
        end
        checks++;
        if (f != n + 9) begin errors++; $display("FAIL single_busy_fall got %0d expected %0d", f - n, 9); end
        checks++;
        if (grant !== 2'b00 || lcd_data !== 8'h38) begin
            errors++; $display("FAIL single_idle got grant %b data %h expected 00 38", grant, lcd_data);
        end
        @(posedge clk); #2 manualDone = 1'b1;
        @(posedge clk); #2 manualDone = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || lcd_start !== 1'b0) begin
            errors++; $display("FAIL idle_done_ignored got busy %b start %b expected 0 0", busy, lcd_start);
        end
    endtask

    task automatic test_round_robin;
        int idx, c, prev, exp;
        doReset();
        req_data = 16'hB1A0; req_rs = 2'b10; req_last = 2'b11; req_valid = 2'b11;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            waitAcc(idx, c);
            exp = i % 2;
            checks++;
            if (idx !== exp) begin errors++; $display("FAIL rr_winner byte %0d got %0d expected %0d", i, idx, exp); end
            if (i > 0) begin
                checks++;
                if (c - prev != 7) begin
                    if (c - prev != 9) begin
                        errors++; $display("FAIL rr_period got %0d expected 9", c - prev);
                    end
                end else begin
                    errors++; $display("FAIL rr_period got %0d expected 9", c - prev);
                end
            end
            prev = c;
            @(posedge clk); #2;
            @(negedge clk);
            checks++;
            if (lcd_data !== ((exp == 1) ? 8'hB1 : 8'hA0) || lcd_rs !== ((exp == 1) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL rr_data byte %0d got %h rs %b", i, lcd_data, lcd_rs);
            end
        end
        @(posedge clk); #2 req_valid = 2'b00;
    endtask

    task automatic test_lock;
        int idx, c1, c2, c3;
        doReset();
        req_data = {8'h80, 8'h11}; req_rs = 2'b01; req_last = 2'b01; req_valid = 2'b10;
        waitAcc(idx, c1);
        checks++;
        if (idx !== 1) begin errors++; $display("FAIL lock_first got %0d expected 1", idx); end
        @(posedge clk); #2;
        req_data[15:8] = 8'h57; req_rs[1] = 1'b1; req_last[1] = 1'b1; req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (lcd_data !== 8'h80 || lcd_rs !== 1'b0) begin
            errors++; $display("FAIL lock_cmd_byte got %h rs %b expected 80 rs 0", lcd_data, lcd_rs);
        end
        waitAcc(idx, c2);
        checks++;
        if (idx !== 1 || c2 - c1 != 9) begin
            errors++; $display("FAIL lock_second got owner %0d gap %0d expected 1 9", idx, c2 - c1);
        end
        @(posedge clk); #2 req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (lcd_data !== 8'h57 || lcd_rs !== 1'b1) begin
            errors++; $display("FAIL lock_data_byte got %h rs %b expected 57 rs 1", lcd_data, lcd_rs);
        end
        waitAcc(idx, c3);
        checks++;
        if (idx !== 0 || c3 - c2 != 9) begin
            errors++; $display("FAIL lock_release got owner %0d gap %0d expected 0 9", idx, c3 - c2);
        end
        @(posedge clk); #2 req_valid = 2'b00;
    endtask

    task automatic test_lock_stall;
        int idx, c, badRdy, badGrant;
        doReset();
        req_data = {8'h80, 8'h22}; req_rs = 2'b01; req_last = 2'b01; req_valid = 2'b10;
        waitAcc(idx, c);
        checks++;
        if (idx !== 1) begin errors++; $display("FAIL stall_first got %0d expected 1", idx); end
        @(posedge clk); #2 req_valid = 2'b01;
        badRdy = 0; badGrant = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_ready !== 2'b00) badRdy++;
            if (grant !== 2'b10) badGrant++;
        end
        checks++;
        if (badRdy != 0) begin errors++; $display("FAIL stall_ready got %0d strobes expected 0", badRdy); end
        checks++;
        if (badGrant != 0) begin errors++; $display("FAIL stall_grant got %0d bad cycles expected 0", badGrant); end
        @(posedge clk); #2;
        req_data[15:8] = 8'h57; req_last[1] = 1'b1; req_valid = 2'b11;
        waitAcc(idx, c);
        checks++;
        if (idx !== 1) begin errors++; $display("FAIL stall_resume got %0d expected 1", idx); end
        @(posedge clk); #2 req_valid = 2'b01;
        waitAcc(idx, c);
        checks++;
        if (idx !== 0) begin errors++; $display("FAIL stall_other got %0d expected 0", idx); end
        @(posedge clk); #2 req_valid = 2'b00;
    endtask

    task automatic test_timeout;
        int idx, n, c, r;
`ifdef LCD_ARB_TIMEOUT_EN
        doReset();
        doneEn = 1'b0;
        req_data = {8'h66, 8'h55}; req_rs = 2'b00; req_last = 2'b10; req_valid = 2'b01;
        waitAcc(idx, n);
        checks++;
        if (idx !== 0) begin errors++; $display("FAIL timeout_first got %0d expected 0", idx); end
        @(posedge clk); #2 req_valid = 2'b11;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_err === 1'b1) begin r = cyc; break; end
        end
        checks++;
        if (r != n + 12) begin errors++; $display("FAIL timeout_rise got %0d expected %0d", r - n, 12); end
        doneEn = 1'b1;
        waitAcc(idx, c);
        checks++;
        if (idx !== 1) begin errors++; $display("FAIL timeout_next_owner got %0d expected 1", idx); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b expected 1", timeout_err); end
        @(posedge clk); #2 req_valid = 2'b00;
        doReset();
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b expected 0", timeout_err); end
`else
        doReset();
        doneEn = 1'b0;
        req_data[7:0] = 8'h55; req_last = 2'b11; req_valid = 2'b01;
        waitAcc(idx, n);
        @(posedge clk); #2 req_valid = 2'b00;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL wait_forever got busy %b terr %b expected 1 0", busy, timeout_err);
        end
        @(posedge clk); #2 manualDone = 1'b1;
        c = cyc;
        @(posedge clk); #2 manualDone = 1'b0;
        r = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin r = cyc; break; end
        end
        checks++;
        if (r != c + 5) begin errors++; $display("FAIL late_done_fall got %0d expected 5", r - c); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_lock();
        test_lock_stall();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Round-robin arbiter that shares the single LCD_Controller byte port between several independent requesters, for example an init sequencer and a text writer. Each accepted byte is issued to the controller, the block waits for its done strobe, then holds a programmable settle delay before serving anyone else. A requester can lock the port for a multi-byte transaction, such as a cursor-address command followed by 16 characters, so no other requester can interleave bytes with it.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..4.
- DLY_CYCLES, 262142: settle cycles after each lcd_done; 0 means no settle phase.
- TIMEOUT_CYCLES, 1000000: maximum WAIT_DONE cycles. Used only with LCD_ARB_TIMEOUT_EN.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset. Synchronous, active-high.
- req_valid, in, NREQ: requester i has a byte pending.
- req_data, in, 8*NREQ: byte for requester i, at bits [8i+7:8i].
- req_rs, in, NREQ: RS for requester i; 1 = data, 0 = command.
- req_last, in, NREQ: 1 = this byte ends the transaction; 0 = keep the lock.
- req_ready, out, NREQ: one-hot, one-cycle accept strobe.
- lcd_data, out, 8: byte to the controller.
- lcd_rs, out, 1: RS to the controller.
- lcd_start, out, 1: one-cycle issue pulse.
- lcd_done, in, 1: controller completion strobe.
- grant, out, NREQ: one-hot current owner; 0 when there is no owner.
- busy, out, 1: high when state is not IDLE.
- timeout_err, out, 1: sticky error flag.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, SETTLE.
- IDLE, unlocked:
  - Winner = first i with req_valid[i] set, searching from rr_ptr upward and wrapping modulo NREQ.
  - Assert req_ready[winner] in that same cycle; that cycle is the transfer.
  - Register req_data and req_rs into lcd_data and lcd_rs.
  - Set grant to one-hot(winner).
  - Go to ISSUE.
- IDLE, locked:
  - Only the lock owner is eligible.
  - If the owner's req_valid is low, wait with no timeout. Other requesters stall.
- ISSUE:
  - lcd_start = 1 for exactly one cycle.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Wait for lcd_done = 1.
  - lcd_done is ignored in every state except WAIT_DONE.
  - On lcd_done, go to SETTLE, or to IDLE directly if DLY_CYCLES = 0.
- SETTLE:
  - Count up from 0 for DLY_CYCLES cycles, then go to IDLE.
  - The counter width is $clog2(DLY_CYCLES+1) and the counter clears on exit.
- Lock rules:
  - lock is set when the accepted byte has req_last = 0, and cleared when the accepted byte has req_last = 1.
  - On return to IDLE after a last byte: rr_ptr = (owner+1) mod NREQ, grant = 0.
  - While locked, grant stays on the owner through IDLE.
- lcd_data and lcd_rs hold their value until the next accept.
- Reset values: lcd_data 0, lcd_rs 0, lcd_start 0, req_ready 0, grant 0, busy 0, timeout_err 0, rr_ptr 0, lock 0, state IDLE, counters 0.
- Reset asserted mid-transaction aborts it immediately: no further lcd_start is issued and the lock is dropped.

## Timing
- Accept at cycle N gives lcd_start at N+1, and lcd_data/lcd_rs valid from N+1.
- lcd_done at cycle M puts the block back in IDLE at M+1+DLY_CYCLES. The next accept can happen in that IDLE cycle.
- If lcd_done arrives in the cycle immediately after lcd_start, the block enters SETTLE in the next cycle.
- Minimum byte period is 3 + DLY_CYCLES cycles when lcd_done returns one cycle after lcd_start.
- At most one req_ready bit is high in any cycle, and only while in IDLE.
- If all req_valid go high in the same cycle, the lowest index at or above rr_ptr wins.

## Configuration
- LCD_ARB_TIMEOUT_EN defined:
  - A WAIT_DONE counter runs.
  - If it reaches TIMEOUT_CYCLES without lcd_done, set timeout_err (cleared only by rst).
  - Clear lock, advance rr_ptr past the owner, clear grant, and go to SETTLE.
- LCD_ARB_TIMEOUT_EN undefined:
  - No timeout counter; WAIT_DONE waits indefinitely.
  - timeout_err is tied to 0.

## Test plan
Bench setup: NREQ = 2, DLY_CYCLES = 4, and a controller model that pulses lcd_done 3 cycles after lcd_start.
- Reset: hold rst high for 2 cycles with req_valid = 2'b11. All outputs stay 0 and no req_ready fires. After release, req0 is accepted first.
- Single byte: req0 sends 8'h38, rs 0, last 1.
  - req_ready[0] at cycle N.
  - lcd_start at N+1 with lcd_data = 8'h38.
  - busy falls 8 cycles after the lcd_start cycle, and grant returns to 0.
- Round robin: both requesters hold valid with last = 1. Grants alternate req0, req1, req0, req1 over 4 bytes.
- Lock: req1 sends 8'h80 with last 0, then 8'h57 with last 1, while req0 is valid throughout. The controller sees 80 then 57 back to back, and req0 is served only after that.
- Locked owner stalls: req1 drops valid for 20 cycles mid-lock. No req_ready to req0 during the stall, and grant stays 2'b10.
- Timeout, macro defined: TIMEOUT_CYCLES = 10, lcd_done never comes.
  - timeout_err rises 10 cycles after WAIT_DONE entry and stays high.
  - The next accept goes to the other requester.
